// File: rtl/pwm_bank.sv
// Multi-channel PWM generator: shared edge/center-aligned counter, per-channel shadow levels
// that take effect only at period boundaries. Outputs and period_start are registered (1-cycle latency).
module pwm_bank #(
  parameter int              WIDTH  = 8,
  parameter int              NCH    = 3,
  parameter logic [NCH-1:0]  INVERT = '0,
  parameter int              CHW    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] top,
  input  logic             center,
  input  logic             wr_en,
  input  logic [CHW-1:0]   wr_ch,
  input  logic [WIDTH-1:0] wr_level,
  output logic [NCH-1:0]   out,
  output logic             period_start
);

  logic [WIDTH-1:0] count, count_nxt;
  logic             down, down_nxt;
  logic [WIDTH-1:0] top_a;
  logic             center_a;
  logic [WIDTH-1:0] shadow     [NCH];
  logic [WIDTH-1:0] shadow_nxt [NCH];
  logic [WIDTH-1:0] level_a    [NCH];
  logic [NCH-1:0]   on;
  logic             load;

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      shadow_nxt[c] = shadow[c];
      if (wr_en && wr_ch == CHW'(c))
        shadow_nxt[c] = wr_level;
    end
  end

  // Counter sequencing; a wrap is any en=1 edge whose next count is zero.
  always_comb begin
    count_nxt = '0;
    down_nxt  = 1'b0;
    if (en && top_a != '0) begin
      if (!center_a) begin
        count_nxt = (count >= top_a) ? '0 : count + 1'b1;
      end else if (!down) begin
        if (count >= top_a) begin
          count_nxt = top_a - 1'b1;
          down_nxt  = 1'b1;
        end else begin
          count_nxt = count + 1'b1;
        end
      end else begin
        count_nxt = count - 1'b1;
        down_nxt  = 1'b1;
      end
      if (count_nxt == '0)
        down_nxt = 1'b0;
    end
  end

  assign load = !en || (count_nxt == '0);

  always_comb begin
    for (int c = 0; c < NCH; c++)
      on[c] = (count < level_a[c]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count        <= '0;
      down         <= 1'b0;
      top_a        <= '0;
      center_a     <= 1'b0;
      out          <= INVERT;
      period_start <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        shadow[c]  <= '0;
        level_a[c] <= '0;
      end
    end else begin
      count        <= count_nxt;
      down         <= down_nxt;
      out          <= en ? (on ^ INVERT) : INVERT;
      period_start <= en && (count == '0);
      for (int c = 0; c < NCH; c++)
        shadow[c] <= shadow_nxt[c];
      // Same-edge writes are visible to the load so new data wins.
      if (load) begin
        top_a    <= top;
        center_a <= center;
        for (int c = 0; c < NCH; c++)
          level_a[c] <= shadow_nxt[c];
      end
    end
  end

endmodule

// File: tb/tb_pwm_bank.sv
// Directed bench for pwm_bank: cycle table for edge mode, then center-mode and reset sequences.
module tb_pwm_bank;

  logic       clk = 1'b0;
  logic       reset, en, center, wr_en;
  logic [7:0] top, wr_level;
  logic [1:0] wr_ch;
  logic [2:0] out;
  logic       period_start;

  int total = 0;
  int bad   = 0;

  pwm_bank #(.WIDTH(8), .NCH(3), .INVERT(3'b010), .CHW(2)) dut (
    .clk(clk), .reset(reset), .en(en), .top(top), .center(center),
    .wr_en(wr_en), .wr_ch(wr_ch), .wr_level(wr_level),
    .out(out), .period_start(period_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic [7:0] top;
    logic       ctr;
    logic       we;
    logic [1:0] ch;
    logic [7:0] lvl;
    logic [2:0] eo;
    logic       eps;
  } vec_t;

  vec_t tbl [26];

  task automatic step(input logic r, input logic e, input logic [7:0] t, input logic c,
                      input logic w, input logic [1:0] ch, input logic [7:0] l);
    reset = r; en = e; top = t; center = c; wr_en = w; wr_ch = ch; wr_level = l;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int idx, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %b expected %b", name, idx, got, exp);
    end
  endtask

  initial begin
    //              rst en top ctr we ch lvl  out     ps
    tbl[0]  = '{1'b1,1'b0,8'd9,1'b0,1'b0,2'd0,8'd0, 3'b010,1'b0};
    tbl[1]  = '{1'b0,1'b0,8'd9,1'b0,1'b1,2'd0,8'd3, 3'b010,1'b0};
    tbl[2]  = '{1'b0,1'b0,8'd9,1'b0,1'b1,2'd1,8'd2, 3'b010,1'b0};
    tbl[3]  = '{1'b0,1'b1,8'd9,1'b0,1'b0,2'd0,8'd0, 3'b001,1'b1};
    tbl[4]  = '{1'b0,1'b1,8'd9,1'b0,1'b0,2'd0,8'd0, 3'b001,1'b0};
    tbl[5]  = '{1'b0,1'b1,8'd9,1'b0,1'b0,2'd0,8'd0, 3'b011,1'b0};
    tbl[6]  = '{1'b0,1'b1,8'd9,1'b0,1'b0,2'd0,8'd0, 3'b010,1'b0};
    tbl[7]  = '{1'b0,1'b1,8'd9,1'b0,1'b1,2'd3,8'd99,3'b010,1'b0};
    tbl[8]  = '{1'b0,1'b1,8'd9,1'b0,1'b1,2'd1,8'd7, 3'b010,1'b0};
    tbl[9]  = '{1'b0,1'b1,8'd3,1'b0,1'b0,2'd0,8'd0, 3'b010,1'b0};
    tbl[10] = '{1'b0,1'b1,8'd3,1'b0,1'b0,2'd0,8'd0, 3'b010,1'b0};
    tbl[11] = '{1'b0,1'b1,8'd3,1'b0,1'b0,2'd0,8'd0, 3'b010,1'b0};
    tbl[12] = '{1'b0,1'b1,8'd3,1'b0,1'b0,2'd0,8'd0, 3'b010,1'b0};
    tbl[13] = '{1'b0,1'b1,8'd3,1'b0,1'b0,2'd0,8'd0, 3'b001,1'b1};
    tbl[14] = '{1'b0,1'b1,8'd3,1'b0,1'b0,2'd0,8'd0, 3'b001,1'b0};
    tbl[15] = '{1'b0,1'b1,8'd3,1'b0,1'b0,2'd0,8'd0, 3'b001,1'b0};
    tbl[16] = '{1'b0,1'b1,8'd3,1'b0,1'b1,2'd1,8'd1, 3'b000,1'b0};
    tbl[17] = '{1'b0,1'b1,8'd3,1'b0,1'b0,2'd0,8'd0, 3'b001,1'b1};
    tbl[18] = '{1'b0,1'b1,8'd3,1'b0,1'b0,2'd0,8'd0, 3'b011,1'b0};
    tbl[19] = '{1'b0,1'b1,8'd3,1'b0,1'b0,2'd0,8'd0, 3'b011,1'b0};
    tbl[20] = '{1'b0,1'b1,8'd3,1'b0,1'b0,2'd0,8'd0, 3'b010,1'b0};
    tbl[21] = '{1'b0,1'b1,8'd3,1'b0,1'b0,2'd0,8'd0, 3'b001,1'b1};
    tbl[22] = '{1'b0,1'b0,8'd3,1'b0,1'b0,2'd0,8'd0, 3'b010,1'b0};
    tbl[23] = '{1'b0,1'b0,8'd3,1'b0,1'b0,2'd0,8'd0, 3'b010,1'b0};
    tbl[24] = '{1'b0,1'b1,8'd3,1'b0,1'b0,2'd0,8'd0, 3'b001,1'b1};
    tbl[25] = '{1'b0,1'b1,8'd3,1'b0,1'b0,2'd0,8'd0, 3'b011,1'b0};

    reset = 1'b1; en = 1'b0; top = '0; center = 1'b0;
    wr_en = 1'b0; wr_ch = '0; wr_level = '0;
    #2;

    for (int i = 0; i < 26; i++) begin
      step(tbl[i].rst, tbl[i].en, tbl[i].top, tbl[i].ctr, tbl[i].we, tbl[i].ch, tbl[i].lvl);
      check("tbl_out", i, {1'b0, out}, {1'b0, tbl[i].eo});
      check("tbl_ps",  i, {3'b0, period_start}, {3'b0, tbl[i].eps});
    end

    // Center mode, top=4: ch0 level 2 (3 of 8 high), ch1 level 0 (never), ch2 level 5 (always).
    step(1'b0, 1'b0, 8'd4, 1'b1, 1'b1, 2'd0, 8'd2);
    step(1'b0, 1'b0, 8'd4, 1'b1, 1'b1, 2'd1, 8'd0);
    step(1'b0, 1'b0, 8'd4, 1'b1, 1'b1, 2'd2, 8'd5);
    check("ctr_idle_out", 0, {1'b0, out}, 4'b0010);
    begin
      logic [7:0] hi_mask;
      hi_mask = 8'b1000_0011;
      for (int k = 0; k < 16; k++) begin
        step(1'b0, 1'b1, 8'd4, 1'b1, 1'b0, 2'd0, 8'd0);
        check("ctr_out", k, {1'b0, out}, {1'b0, 1'b1, 1'b1, hi_mask[k % 8]});
        check("ctr_ps",  k, {3'b0, period_start}, {3'b0, (k % 8) == 0});
      end
    end

    // Reset mid-period with nonzero levels, then run with no new writes.
    step(1'b0, 1'b1, 8'd4, 1'b1, 1'b0, 2'd0, 8'd0);
    step(1'b0, 1'b1, 8'd4, 1'b1, 1'b0, 2'd0, 8'd0);
    step(1'b1, 1'b1, 8'd4, 1'b1, 1'b1, 2'd0, 8'd9);
    check("rst_out", 0, {1'b0, out}, 4'b0010);
    check("rst_ps",  0, {3'b0, period_start}, 4'b0000);
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b1, 8'd4, 1'b1, 1'b0, 2'd0, 8'd0);
      check("post_rst_out", k, {1'b0, out}, 4'b0010);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
